i2c_slave_responder: RTL and testbench

//  I2C target (responder) for the other end of the bus driven by i2c_master. Oversamples SCL/SDA on clk.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_slave_responder.sv | 198 +++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C responder and its bus synchroniser.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } slave_state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives single-cycle edge and START/STOP strobes.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Flops reset to the idle-bus level so reset release cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: matches a fixed address, delivers written bytes and serves read bytes from the user side.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2c_scl,
    inout  wire                   i2c_sda,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam logic [3:0] ADDR_BITS = 4'(ADDR_WIDTH + 1);
    localparam logic [3:0] DATA_BITS = 4'(DATA_WIDTH);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    slave_state_t          state, state_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [DATA_WIDTH-1:0] tx_reg, tx_n;
    logic                  rw, rw_n;
    logic                  master_ack, master_ack_n;
    logic                  sda_drive_low, drive_n;
    logic [DATA_WIDTH-1:0] data_out_n;
    logic                  valid_n;
    logic                  busy_n;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (i2c_scl),
        .sda       (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign i2c_sda = sda_drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            tx_reg        <= '0;
            rw            <= RW_WRITE;
            master_ack    <= NACK;
            sda_drive_low <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift_reg     <= shift_n;
            tx_reg        <= tx_n;
            rw            <= rw_n;
            master_ack    <= master_ack_n;
            sda_drive_low <= drive_n;
            data_out      <= data_out_n;
            data_valid    <= valid_n;
            busy          <= busy_n;
        end
    end

    // Bus conditions override any coincident SCL edge; data_req is combinational so it
    // marks exactly the cycle in which data_in is loaded into the TX shifter.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_reg;
        tx_n         = tx_reg;
        rw_n         = rw;
        master_ack_n = master_ack;
        drive_n      = sda_drive_low;
        data_out_n   = data_out;
        valid_n      = 1'b0;
        data_req     = 1'b0;
        busy_n       = busy;

        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            drive_n   = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            drive_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drive_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[DATA_WIDTH-2:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == ADDR_BITS) begin
                        bit_cnt_n = '0;
                        // Address 0 (general call) is deliberately never claimed.
                        if (shift_reg[ADDR_WIDTH:1] == SLAVE_ADDR &&
                            shift_reg[ADDR_WIDTH:1] != '0) begin
                            state_n = ADDR_ACK;
                            drive_n = 1'b1;
                            busy_n  = 1'b1;
                            rw_n    = shift_reg[0];
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw == RW_READ) begin
                            state_n  = READ;
                            data_req = 1'b1;
                            tx_n     = data_in;
                            drive_n  = ~data_in[DATA_WIDTH-1];
                        end else begin
                            state_n = WRITE;
                            drive_n = 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[DATA_WIDTH-2:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == DATA_BITS - 4'd1) begin
                            data_out_n = {shift_reg[DATA_WIDTH-2:0], sda_s};
                            valid_n    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == DATA_BITS) begin
                        state_n   = WRITE_ACK;
                        bit_cnt_n = '0;
                        drive_n   = 1'b1;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        state_n = WRITE;
                        drive_n = 1'b0;
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == DATA_BITS) begin
                            state_n   = READ_ACK;
                            bit_cnt_n = '0;
                            drive_n   = 1'b0;
                        end else begin
                            tx_n    = {tx_reg[DATA_WIDTH-2:0], 1'b0};
                            drive_n = ~tx_reg[DATA_WIDTH-2];
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        master_ack_n = sda_s;
                    end else if (scl_fall) begin
                        if (master_ack == ACK) begin
                            state_n  = READ;
                            data_req = 1'b1;
                            tx_n     = data_in;
                            drive_n  = ~data_in[DATA_WIDTH-1];
                        end else begin
                            state_n = IGNORE;
                            drive_n = 1'b0;
                        end
                    end
                end
                IGNORE: begin
                    drive_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    drive_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bus-level bench for i2c_slave_responder with byte scoreboards for writes and reads.
module tb_i2c_slave_responder;

    localparam time Q = 80ns;

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda_low;
    wire        sda_bus;
    logic [7:0] data_in;
    logic       data_req;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int valid_pulses = 0;
    int req_pulses   = 0;

    logic [7:0] wr_exp_q[$];
    logic [7:0] rd_exp_q[$];

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_responder dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_scl    (scl),
        .i2c_sda    (sda_bus),
        .data_in    (data_in),
        .data_req   (data_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5ns clk = ~clk;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Written bytes are popped and compared at the cycle the DUT flags them.
    always @(negedge clk) begin
        if (data_req) req_pulses++;
        if (data_valid) begin
            valid_pulses++;
            check_output("valid_expected", 8'(wr_exp_q.size() > 0), 8'd1);
            if (wr_exp_q.size() > 0) check_output("wr_byte", data_out, wr_exp_q.pop_front());
        end
    end

    task automatic apply_stimulus(input logic b, output logic rd);
        sda_low = ~b;
        #Q scl = 1'b1;
        #Q rd = sda_bus;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q sda_low = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) apply_stimulus(b[i], dummy);
        apply_stimulus(1'b1, ack);
    endtask

    task automatic read_bits(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) apply_stimulus(1'b1, d[i]);
    endtask

    logic       ack;
    logic       dummy;
    logic [7:0] rd;
    int         v0;
    int         r0;

    initial begin
        rst = 1'b1; scl = 1'b1; sda_low = 1'b0; data_in = 8'h00;
        #23ns rst = 1'b0;
        #Q;
        check_output("rst_sda", 8'(sda_bus), 8'd1);
        check_output("rst_busy", 8'(busy), 8'd0);
        check_output("rst_data_out", data_out, 8'h00);
        check_output("rst_valid", 8'(data_valid), 8'd0);
        check_output("rst_req", 8'(data_req), 8'd0);

        // Single byte write to our address
        i2c_start();
        write_byte(8'hA0, ack);
        check_output("wr_addr_ack", 8'(ack), 8'(0));
        check_output("wr_busy", 8'(busy), 8'd1);
        wr_exp_q.push_back(8'hA5);
        write_byte(8'hA5, ack);
        check_output("wr_data_ack", 8'(ack), 8'd0);
        i2c_stop();
        #Q;
        check_output("wr_busy_after_stop", 8'(busy), 8'd0);
        check_output("wr_data_out", data_out, 8'hA5);
        check_output("wr_valid_pulses", 8'(valid_pulses), 8'd1);

        // Foreign address is not acknowledged
        v0 = valid_pulses;
        i2c_start();
        write_byte(8'hA2, ack);
        check_output("mis_nack", 8'(ack), 8'd1);
        check_output("mis_busy", 8'(busy), 8'd0);
        write_byte(8'h77, ack);
        check_output("mis_data_nack", 8'(ack), 8'd1);
        i2c_stop();
        #Q;
        check_output("mis_no_valid", 8'(valid_pulses - v0), 8'd0);

        // Two-byte read, master ACK then NACK
        r0 = req_pulses;
        data_in = 8'h3C;
        rd_exp_q.push_back(8'h3C);
        i2c_start();
        write_byte(8'hA1, ack);
        check_output("rd_addr_ack", 8'(ack), 8'd0);
        read_bits(rd);
        check_output("rd_byte0", rd, rd_exp_q.pop_front());
        data_in = 8'hC3;
        rd_exp_q.push_back(8'hC3);
        apply_stimulus(1'b0, dummy);
        read_bits(rd);
        check_output("rd_byte1", rd, rd_exp_q.pop_front());
        apply_stimulus(1'b1, dummy);
        check_output("rd_sda_released", 8'(sda_bus), 8'd1);
        check_output("rd_req_pulses", 8'(req_pulses - r0), 8'd2);
        i2c_stop();
        #Q;
        check_output("rd_busy_after_stop", 8'(busy), 8'd0);

        // Write, repeated START, then read
        i2c_start();
        write_byte(8'hA0, ack);
        check_output("rs_addr_ack", 8'(ack), 8'd0);
        wr_exp_q.push_back(8'h11);
        write_byte(8'h11, ack);
        check_output("rs_data_ack", 8'(ack), 8'd0);
        data_in = 8'h5A;
        rd_exp_q.push_back(8'h5A);
        i2c_start();
        check_output("rs_busy_at_restart", 8'(busy), 8'd1);
        write_byte(8'hA1, ack);
        check_output("rs_read_ack", 8'(ack), 8'd0);
        check_output("rs_busy_read", 8'(busy), 8'd1);
        read_bits(rd);
        check_output("rs_rd_byte", rd, rd_exp_q.pop_front());
        apply_stimulus(1'b1, dummy);
        i2c_stop();
        #Q;
        check_output("rs_data_out", data_out, 8'h11);
        check_output("rs_busy_after_stop", 8'(busy), 8'd0);

        // STOP after a partial data byte
        v0 = valid_pulses;
        i2c_start();
        write_byte(8'hA0, ack);
        check_output("part_addr_ack", 8'(ack), 8'd0);
        apply_stimulus(1'b1, dummy);
        apply_stimulus(1'b0, dummy);
        apply_stimulus(1'b1, dummy);
        apply_stimulus(1'b0, dummy);
        i2c_stop();
        #Q;
        check_output("part_no_valid", 8'(valid_pulses - v0), 8'd0);
        check_output("part_data_out", data_out, 8'h11);
        check_output("part_busy", 8'(busy), 8'd0);

        // Reset while the slave is pulling the address ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'hA0;
            apply_stimulus(a[i], dummy);
        end
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q;
        check_output("rst_ack_driven", 8'(sda_bus), 8'd0);
        rst = 1'b1;
        #1ns;
        check_output("rst_mid_sda", 8'(sda_bus), 8'd1);
        check_output("rst_mid_busy", 8'(busy), 8'd0);
        check_output("rst_mid_data_out", data_out, 8'h00);
        check_output("rst_mid_valid", 8'(data_valid), 8'd0);
        check_output("rst_mid_req", 8'(data_req), 8'd0);
        #Q;
        rst = 1'b0;
        scl = 1'b0;
        #Q;
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        check_output("post_rst_addr_ack", 8'(ack), 8'd0);
        wr_exp_q.push_back(8'h5A);
        write_byte(8'h5A, ack);
        check_output("post_rst_data_ack", 8'(ack), 8'd0);
        i2c_stop();
        #Q;
        check_output("post_rst_data_out", data_out, 8'h5A);

        check_output("wr_queue_drained", 8'(wr_exp_q.size()), 8'd0);
        check_output("rd_queue_drained", 8'(rd_exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
